sync_scheduler: RTL and testbench

SYNC_SCHEDULER -- requirements
Module: sync_scheduler

---
 rtl/sync_scheduler.sv | 143 ++++++++++++++
 tb/tb_sync_scheduler.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sync_scheduler.sv
// Sync scheduler: starts internet-time syncs on keypad request or on a seconds period,
// with per-attempt watchdog, backoff and retry. Periodic syncing is built only when SYNC_SCHED_PERIODIC_EN is defined.
module sync_scheduler #(
  parameter int SYNC_PERIOD_S = 3600,
  parameter int TIMEOUT_CYC   = 100000000,
  parameter int BACKOFF_CYC   = 1000,
  parameter int MAX_TRY       = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       manual_req,
  input  logic       ts_finished,
  output logic       ts_en,
  output logic       busy,
  output logic       sync_ok,
  output logic       sync_fail,
  output logic       last_ok,
  output logic [2:0] try_cnt
);

  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int BO_W = (BACKOFF_CYC > 1) ? $clog2(BACKOFF_CYC) : 1;

  typedef enum logic [1:0] {IDLE, RUN, BACKOFF, DONE} state_t;

  state_t            state, state_next;
  logic [WD_W-1:0]   wd_cnt, wd_next;
  logic [BO_W-1:0]   bo_cnt, bo_next;
  logic [2:0]        try_next;
  logic              ok_next, fail_next, last_next;
  logic              period_expire;
  logic              start;

`ifdef SYNC_SCHED_PERIODIC_EN
  localparam int PER_W = (SYNC_PERIOD_S > 1) ? $clog2(SYNC_PERIOD_S) : 1;
  logic [PER_W-1:0] period_cnt;

  assign period_expire = (state == IDLE) && tick_1hz &&
                         (period_cnt == PER_W'(SYNC_PERIOD_S - 1));

  // Counts seconds only while idle; any start (manual or expiry) restarts the period.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_cnt <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        period_cnt <= '0;
      end else if (tick_1hz) begin
        period_cnt <= period_cnt + PER_W'(1);
      end
    end
  end
`else
  localparam int unused_period_s = SYNC_PERIOD_S;
  logic unused_tick;
  assign unused_tick   = tick_1hz;
  assign period_expire = 1'b0;
`endif

  assign start = manual_req || period_expire;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_next = state;
    wd_next    = wd_cnt;
    bo_next    = bo_cnt;
    try_next   = try_cnt;
    ok_next    = 1'b0;
    fail_next  = 1'b0;
    last_next  = last_ok;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          try_next   = 3'd1;
          wd_next    = '0;
        end
      end
      RUN: begin
        // Success is tested first so it wins over a coinciding timeout.
        if (ts_finished) begin
          state_next = DONE;
          ok_next    = 1'b1;
          last_next  = 1'b1;
        end else if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
          if (try_cnt < 3'(MAX_TRY)) begin
            state_next = BACKOFF;
            bo_next    = '0;
          end else begin
            state_next = DONE;
            fail_next  = 1'b1;
            last_next  = 1'b0;
          end
        end else begin
          wd_next = wd_cnt + WD_W'(1);
        end
      end
      BACKOFF: begin
        if (bo_cnt == BO_W'(BACKOFF_CYC - 1)) begin
          state_next = RUN;
          try_next   = try_cnt + 3'd1;
          wd_next    = '0;
        end else begin
          bo_next = bo_cnt + BO_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
        try_next   = 3'd0;
      end
      default: state_next = IDLE;
    endcase
  end

  // ts_en and busy are decoded from the next state and registered, so they
  // track the state register exactly with no input-to-output path.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and covers every register; state uses non-blocking assignments only.
    if (reset) begin
      state     <= IDLE;
      wd_cnt    <= '0;
      bo_cnt    <= '0;
      try_cnt   <= 3'd0;
      sync_ok   <= 1'b0;
      sync_fail <= 1'b0;
      last_ok   <= 1'b0;
      ts_en     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      wd_cnt    <= wd_next;
      bo_cnt    <= bo_next;
      try_cnt   <= try_next;
      sync_ok   <= ok_next;
      sync_fail <= fail_next;
      last_ok   <= last_next;
      ts_en     <= (state_next == RUN);
      busy      <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_sync_scheduler.sv
// Self-checking bench for sync_scheduler: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_sync_scheduler;

  localparam int P  = 4;
  localparam int T  = 20;
  localparam int B  = 3;
  localparam int MT = 3;
`ifdef SYNC_SCHED_PERIODIC_EN
  localparam bit PERIODIC = 1'b1;
`else
  localparam bit PERIODIC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, tick_1hz, manual_req, ts_finished;
  logic       ts_en, busy, sync_ok, sync_fail, last_ok;
  logic [2:0] try_cnt;

  int vectors    = 0;
  int miscompares = 0;
  bit cmp_en     = 1'b0;

  always #5 clk = ~clk;

  sync_scheduler #(
    .SYNC_PERIOD_S(P), .TIMEOUT_CYC(T), .BACKOFF_CYC(B), .MAX_TRY(MT)
  ) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .manual_req(manual_req),
    .ts_finished(ts_finished), .ts_en(ts_en), .busy(busy), .sync_ok(sync_ok),
    .sync_fail(sync_fail), .last_ok(last_ok), .try_cnt(try_cnt)
  );

  wire [7:0] outs = {ts_en, busy, sync_ok, sync_fail, last_ok, try_cnt};

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Model: attempt number, age inside the current attempt (-1 when not
  // attempting), remaining backoff cycles, and a one-cycle wrap-up flag.
  int m_att = 0, m_age = -1, m_gap = 0, m_ticks = 0;
  bit m_done = 0, m_ok = 0, m_fail = 0, m_last = 0;

  always @(posedge clk) begin : model
    int att, age, gap, tk;
    bit done, ok, fail, last, expire;
    att = m_att; age = m_age; gap = m_gap; tk = m_ticks;
    done = m_done; last = m_last; ok = 1'b0; fail = 1'b0;
    if (reset) begin
      att = 0; age = -1; gap = 0; tk = 0; done = 0; last = 0;
    end else if (done) begin
      done = 0; att = 0;
    end else if (age >= 0) begin
      if (ts_finished) begin
        ok = 1; last = 1; done = 1; age = -1;
      end else if (age == T - 1) begin
        age = -1;
        if (att < MT) gap = B;
        else begin fail = 1; last = 0; done = 1; end
      end else age++;
    end else if (gap > 0) begin
      gap--;
      if (gap == 0) begin att++; age = 0; end
    end else begin
      expire = PERIODIC && tick_1hz && (tk == P - 1);
      if (manual_req || expire) begin att = 1; age = 0; tk = 0; end
      else if (PERIODIC && tick_1hz) tk++;
    end
    m_att <= att; m_age <= age; m_gap <= gap; m_ticks <= tk;
    m_done <= done; m_ok <= ok; m_fail <= fail; m_last <= last;
  end

  wire [7:0] exp_outs = {m_age >= 0, (m_age >= 0) || (m_gap > 0) || m_done,
                         m_ok, m_fail, m_last, 3'(m_att)};

  always @(negedge clk) if (cmp_en) check("cycle_model", outs, exp_outs);

  task automatic step(input bit mr, input bit tk, input bit tf, input bit rst);
    manual_req = mr; tick_1hz = tk; ts_finished = tf; reset = rst;
    @(negedge clk);
  endtask

  initial begin : stim
    bit en[80], fl[80];
    logic [2:0] tc[80];
    int errs, en_sum, fl_sum;

    reset = 1; manual_req = 0; tick_1hz = 0; ts_finished = 0;
    @(negedge clk);
    cmp_en = 1'b1;
    step(0, 0, 0, 1);
    check("reset_state", outs, 8'b0000_0000);
    repeat (8) step(0, 0, 0, 0);

    // Manual sync answered after five enable cycles.
    step(1, 0, 0, 0);
    check("a_run_first", outs, 8'b1100_0001);
    repeat (4) step(0, 0, 0, 0);
    check("a_run_last", outs, 8'b1100_0001);
    step(0, 0, 1, 0);
    check("a_sync_ok", outs, 8'b0110_1001);
    step(0, 0, 0, 0);
    check("a_back_idle", outs, 8'b0000_1000);

    // No answer at all: three windows, one failure.
    step(1, 0, 0, 0);
    for (int i = 0; i < 80; i++) begin
      en[i] = ts_en; fl[i] = sync_fail; tc[i] = try_cnt;
      step(0, 0, 0, 0);
    end
    errs = 0; en_sum = 0; fl_sum = 0;
    for (int i = 0; i < 80; i++) begin
      bit want;
      want = (i <= 19) || (i >= 23 && i <= 42) || (i >= 46 && i <= 65);
      if (en[i] != want) errs++;
      en_sum += int'(en[i]);
      fl_sum += int'(fl[i]);
    end
    check("b_window_errs", 8'(errs), 8'd0);
    check("b_en_cycles", 8'(en_sum), 8'd60);
    check("b_try1", {5'd0, tc[0]}, 8'd1);
    check("b_try2", {5'd0, tc[23]}, 8'd2);
    check("b_try3", {5'd0, tc[46]}, 8'd3);
    check("b_fail_pulses", 8'(fl_sum), 8'd1);
    check("b_fail_at_done", {7'd0, fl[66]}, 8'd1);
    check("b_final", outs, 8'b0000_0000);

    // Answer on the last watchdog cycle of the final attempt.
    step(1, 0, 0, 0);
    repeat (65) step(0, 0, 0, 0);
    check("c_last_wd_cycle", outs, 8'b1100_0011);
    step(0, 0, 1, 0);
    check("c_ok_wins", outs, 8'b0110_1011);
    step(0, 0, 0, 0);
    check("c_idle", outs, 8'b0000_1000);

    // Four seconds in IDLE.
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    check("d_three_ticks", outs, 8'b0000_1000);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
`ifdef SYNC_SCHED_PERIODIC_EN
    check("d_period_start", outs, 8'b1100_1001);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
`else
    check("d_no_period", outs, 8'b0000_1000);
    step(0, 0, 0, 0);
`endif

    // Reset during the second attempt, then a stray finish pulse.
    step(1, 0, 0, 0);
    repeat (23) step(0, 0, 0, 0);
    check("e_try2", outs, 8'b1100_1010);
    step(0, 0, 1, 1);
    check("e_reset", outs, 8'b0000_0000);
    step(0, 0, 1, 0);
    check("e_stray_finish", outs, 8'b0000_0000);

    // Randomized traffic, checked by the per-cycle model compare.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 11) == 0, $urandom_range(0, 999) < 4);
    end
    step(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
